// File: rtl/part_profile_checker.sv
// part_profile_checker
// Replays a stored part profile out of part_mem one word at a time and
// compares each word against the live CCD width stream. Zero samples are
// skipped, END_MARK ends the part early, and samples arriving while the
// checker is not ready are dropped and flagged as an overrun.
//
// Sample handshake: a sample is consumed on a rising clock edge where
// sample_valid=1 and sample_ready=1. sample_ready is high only while
// waiting for a sample. A sample_valid while busy and not ready is dropped
// and sets the sticky overrun flag. sample_valid while idle is ignored.

module part_profile_checker #(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 10,
    parameter int TOLERANCE = 8,
    parameter int END_MARK  = 882,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] part_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic              fail_short,
    output logic              fail_overrun
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FETCH       = 3'd1,
        LATCH       = 3'd2,
        WAIT_SAMPLE = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] ref_reg;

    logic [DATA_W:0]   sample_ext;
    logic [DATA_W:0]   ref_ext;
    logic [DATA_W:0]   diff;
    logic              out_tol;
    logic              is_zero;
    logic              is_end;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] idx_inc;
    logic              last_word;

    // Handshake and memory strobes decode directly from the state register.
    assign mem_rden     = (state == FETCH);
    assign mem_addr     = idx;
    assign sample_ready = (state == WAIT_SAMPLE);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    // Word compare: absolute difference in one extra bit so it never wraps,
    // plus the saturating mismatch count that this compare would produce.
    always_comb begin
        sample_ext = {1'b0, sample_data};
        ref_ext    = {1'b0, ref_reg};
        diff       = '0;
        if (sample_ext >= ref_ext) begin
            diff = sample_ext - ref_ext;
        end else begin
            diff = ref_ext - sample_ext;
        end
        out_tol    = (diff > (DATA_W+1)'(TOLERANCE));
        is_zero    = (sample_data == '0);
        is_end     = (sample_data == DATA_W'(END_MARK));
        count_next = mismatch_count;
        if (out_tol && (mismatch_count != '1)) begin
            count_next = mismatch_count + CNT_W'(1);
        end
        idx_inc    = idx + ADDR_W'(1);
        last_word  = (idx_inc == len_reg);
    end

    // Check sequencer: fetch a word, latch it, wait for a sample, compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            len_reg        <= '0;
            idx            <= '0;
            ref_reg        <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            fail_short     <= 1'b0;
            fail_overrun   <= 1'b0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_reg        <= part_len;
                        idx            <= '0;
                        mismatch_count <= '0;
                        first_fail_idx <= '0;
                        fail_overrun   <= 1'b0;
                        pass           <= 1'b0;
                        if (part_len == '0) begin
                            fail_short <= 1'b1;
                            state      <= DONE;
                        end else begin
                            fail_short <= 1'b0;
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (sample_valid) fail_overrun <= 1'b1;
                    state <= LATCH;
                end
                LATCH: begin
                    if (sample_valid) fail_overrun <= 1'b1;
                    ref_reg <= mem_q;
                    state   <= WAIT_SAMPLE;
                end
                WAIT_SAMPLE: begin
                    if (sample_valid && !is_zero) begin
                        if (is_end) begin
                            fail_short <= 1'b1;
                            pass       <= 1'b0;
                            state      <= DONE;
                        end else begin
                            mismatch_count <= count_next;
                            if (out_tol && (mismatch_count == '0)) begin
                                first_fail_idx <= idx;
                            end
                            // idx stays on the last word so it never reaches len_reg
                            if (last_word) begin
                                pass  <= (count_next == '0) && !fail_short && !fail_overrun;
                                state <= DONE;
                            end else begin
                                idx   <= idx_inc;
                                state <= FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    if (sample_valid) fail_overrun <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_part_profile_checker.sv
// Bench for part_profile_checker: behavioural part_mem, sample driver tasks,
// expected-result and expected-address queues checked by a negedge monitor.

module tb_part_profile_checker;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 10;
    localparam int RW     = 1 + CNT_W + ADDR_W + 1 + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] part_len;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  mismatch_count;
    logic [ADDR_W-1:0] first_fail_idx;
    logic              fail_short;
    logic              fail_overrun;

    logic [DATA_W-1:0] mem [0:1023];
    logic [RW-1:0]     exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];

    int n_checks;
    int n_fail;
    int done_cnt;
    logic prev_done;

    part_profile_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .part_len       (part_len),
        .mem_addr       (mem_addr),
        .mem_rden       (mem_rden),
        .mem_q          (mem_q),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_count (mismatch_count),
        .first_fail_idx (first_fail_idx),
        .fail_short     (fail_short),
        .fail_overrun   (fail_overrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // part_mem model: one-cycle read latency
    always @(posedge clk) begin
        if (mem_rden) mem_q <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input logic p, input int cnt, input int fidx,
                                     input logic sh, input logic ov);
        exp_q.push_back({p, CNT_W'(cnt), ADDR_W'(fidx), sh, ov});
    endfunction

    function automatic void push_addrs(input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(ADDR_W'(i));
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rden) begin
                if (addr_q.size() == 0) begin
                    check("addr_extra", 32'(mem_addr), 32'hFFFF);
                end else begin
                    check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                end
            end
            if (prev_done) begin
                check("done_pulse", 32'(done), 0);
                check("busy_after_done", 32'(busy), 0);
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 0);
                end else begin
                    logic [RW-1:0] e;
                    e = exp_q.pop_front();
                    check("pass",           32'(pass),           32'(e[RW-1]));
                    check("mismatch_count", 32'(mismatch_count), 32'(e[RW-2 -: CNT_W]));
                    check("first_fail_idx", 32'(first_fail_idx), 32'(e[ADDR_W+1 : 2]));
                    check("fail_short",     32'(fail_short),     32'(e[1]));
                    check("fail_overrun",   32'(fail_overrun),   32'(e[0]));
                    check("busy_at_done",   32'(busy),           1);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // driver tasks
    task automatic do_start(input int len, input bit with_sample);
        @(negedge clk);
        start    = 1'b1;
        part_len = ADDR_W'(len);
        if (with_sample) begin
            sample_valid = 1'b1;
            sample_data  = DATA_W'(5);
        end
        @(negedge clk);
        start        = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!sample_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("ready_timeout", 32'(sample_ready), 1);
    endtask

    task automatic send_sample(input int v);
        wait_ready();
        sample_valid = 1'b1;
        sample_data  = DATA_W'(v);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // second sample held for one more cycle lands in FETCH
    task automatic send_burst(input int v1, input int v2);
        wait_ready();
        sample_valid = 1'b1;
        sample_data  = DATA_W'(v1);
        @(negedge clk);
        sample_data  = DATA_W'(v2);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", 32'(done_cnt), 32'(target));
        @(negedge clk);
    endtask

    initial begin
        int target;
        n_checks = 0;
        n_fail = 0;
        done_cnt = 0;
        prev_done = 1'b0;
        start = 1'b0;
        part_len = '0;
        sample_valid = 1'b0;
        sample_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_rden", 32'(mem_rden), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(done), 0);
        check("rst_pass",     32'(pass), 0);
        check("rst_count",    32'(mismatch_count), 0);
        check("rst_fidx",     32'(first_fail_idx), 0);
        check("rst_short",    32'(fail_short), 0);
        check("rst_overrun",  32'(fail_overrun), 0);
        check("rst_ready",    32'(sample_ready), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: all within tolerance, diff 8 included
        mem[0] = 12'd100; mem[1] = 12'd200; mem[2] = 12'd300; mem[3] = 12'd400;
        push_addrs(4);
        push_exp(1'b1, 0, 0, 1'b0, 1'b0);
        target = done_cnt + 1;
        do_start(4, 1'b0);
        send_sample(100); send_sample(205); send_sample(292); send_sample(400);
        wait_done(target);

        // 2: diff 9 at word 1
        push_addrs(4);
        push_exp(1'b0, 1, 1, 1'b0, 1'b0);
        target = done_cnt + 1;
        do_start(4, 1'b0);
        send_sample(100); send_sample(209); send_sample(300); send_sample(400);
        wait_done(target);

        // 3: zeros skipped; sample together with start in idle is ignored
        mem[0] = 12'd50; mem[1] = 12'd60; mem[2] = 12'd70;
        push_addrs(3);
        push_exp(1'b1, 0, 0, 1'b0, 1'b0);
        target = done_cnt + 1;
        do_start(3, 1'b1);
        send_sample(0); send_sample(50); send_sample(0); send_sample(60); send_sample(70);
        wait_done(target);

        // 4a: END_MARK after two good samples
        mem[0] = 12'd100; mem[1] = 12'd200; mem[2] = 12'd300; mem[3] = 12'd400; mem[4] = 12'd500;
        push_addrs(3);
        push_exp(1'b0, 0, 0, 1'b1, 1'b0);
        target = done_cnt + 1;
        do_start(5, 1'b0);
        send_sample(100); send_sample(200); send_sample(882);
        wait_done(target);

        // 4b: zero length ends almost immediately
        push_exp(1'b0, 0, 0, 1'b1, 1'b0);
        target = done_cnt + 1;
        do_start(0, 1'b0);
        @(negedge clk);
        check("len0_latency", 32'(done_cnt), 32'(target));
        wait_done(target);

        // 5a: overrun during FETCH
        mem[0] = 12'd10; mem[1] = 12'd20;
        push_addrs(2);
        push_exp(1'b0, 0, 0, 1'b0, 1'b1);
        target = done_cnt + 1;
        do_start(2, 1'b0);
        send_burst(10, 20);
        send_sample(20);
        wait_done(target);

        // 5b: extreme values, no wrap in either direction
        mem[0] = 12'd0; mem[1] = 12'd4095;
        push_addrs(2);
        push_exp(1'b0, 2, 0, 1'b0, 1'b0);
        target = done_cnt + 1;
        do_start(2, 1'b0);
        send_sample(4095); send_sample(1);
        wait_done(target);

        // 6a: reset in WAIT_SAMPLE at idx 2 with a mismatch already counted
        mem[0] = 12'd100; mem[1] = 12'd200; mem[2] = 12'd300; mem[3] = 12'd400;
        push_addrs(3);
        push_exp(1'b0, 0, 0, 1'b0, 1'b0);
        target = done_cnt;
        do_start(4, 1'b0);
        send_sample(150); send_sample(200);
        wait_ready();
        check("pre_rst_count", 32'(mismatch_count), 1);
        rst = 1'b1;
        #1;
        check("arst_busy",  32'(busy), 0);
        check("arst_count", 32'(mismatch_count), 0);
        check("arst_ready", 32'(sample_ready), 0);
        check("arst_addr",  32'(mem_addr), 0);
        @(negedge clk);
        check("arst_done",  32'(done), 0);
        exp_q.delete();
        check("arst_addr_left", 32'(addr_q.size()), 0);
        addr_q.delete();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("no_done_after_rst", 32'(done_cnt), 32'(target));

        // 6b: normal run after reset, with a start pulse while busy
        push_addrs(4);
        push_exp(1'b1, 0, 0, 1'b0, 1'b0);
        target = done_cnt + 1;
        do_start(4, 1'b0);
        send_sample(101);
        do_start(1, 1'b0);
        send_sample(199); send_sample(300); send_sample(407);
        wait_done(target);

        repeat (4) @(negedge clk);
        check("exp_q_left",  32'(exp_q.size()), 0);
        check("addr_q_left", 32'(addr_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/part_profile_checker.md
Name: part_profile_checker

Overview:
Reads a stored part profile (12-bit widths written by the part memorization logic) back out of part_mem. Compares it word-by-word against a live stream of CCD width samples from ccd_reader and reports a pass/fail verdict for the inspected part. It sits beside the memorize path in the top level and shares part_mem through its read port; it is the consumer of what the memorize logic writes.

Parameters:
DATA_W, 12, width of stored profile words and live samples
ADDR_W, 10, part_mem address width
TOLERANCE, 8, maximum allowed |sample - stored| per word, inclusive
END_MARK, 882, sample value that marks end of part / empty buffer
CNT_W, 10, width of mismatch counter

Ports:
clk  in  1  system clock, CLOCK_50 domain
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse that begins a check; ignored unless busy=0
part_len  in  ADDR_W  number of valid profile words; sampled on accepted start
mem_addr  out  ADDR_W  part_mem read address
mem_rden  out  1  part_mem read enable
mem_q  in  DATA_W  part_mem read data, valid exactly 1 cycle after mem_rden with mem_addr
sample_data  in  DATA_W  live CCD width sample
sample_valid  in  1  single-cycle qualifier for sample_data
sample_ready  out  1  high only in WAIT_SAMPLE
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse at end of check
pass  out  1  verdict, valid from done until next accepted start
mismatch_count  out  CNT_W  words outside tolerance, saturating
first_fail_idx  out  ADDR_W  index of first mismatching word; 0 if none
fail_short  out  1  END_MARK received before part_len words were compared
fail_overrun  out  1  sample_valid seen while sample_ready=0 during busy

Behaviour:
- Reset: state=IDLE. All outputs 0: mem_addr, mem_rden, busy, done, pass, mismatch_count, first_fail_idx, fail_short, fail_overrun. Index and ref registers also 0. Reset mid-check aborts immediately; no done pulse.
- States: IDLE, FETCH, LATCH, WAIT_SAMPLE, DONE.
- IDLE:
  - On start: latch part_len into len_reg and clear idx, all result outputs and pass. Set busy=1.
  - If part_len==0, go to DONE with fail_short=1.
  - Otherwise go to FETCH.
- FETCH: mem_rden=1, mem_addr=idx for this one cycle. Next state is LATCH.
- LATCH: ref_reg<=mem_q. Next state is WAIT_SAMPLE.
- WAIT_SAMPLE: sample_ready=1. Stay until sample_valid. When sample_valid arrives:
  - sample_data==0: consumed, no compare, idx unchanged, stay.
  - sample_data==END_MARK: fail_short=1, go to DONE.
  - Otherwise compare. diff = |sample_data - ref_reg| computed in DATA_W+1 bits, no wrap.
  - diff>TOLERANCE: mismatch_count increments, holding at all-ones. On the first mismatch, first_fail_idx<=idx.
  - After any compare: idx<=idx+1. If idx+1==len_reg go to DONE, else go to FETCH.
- Overrun: sample_valid while busy and state is FETCH, LATCH or DONE sets sticky fail_overrun. That sample is dropped.
- DONE: lasts one cycle.
  - done=1.
  - pass = (mismatch_count==0) && !fail_short && !fail_overrun, using the values including the final compare.
  - busy deasserts on the cycle after done, then state returns to IDLE.
- Results hold until the next accepted start. A start during busy is ignored, with no effect on the check in progress.
- Latency per word: 2 cycles (FETCH, LATCH) plus wait for sample. A sample may be accepted no sooner than 3 cycles after the previous accepted sample.
- Address wrap: idx never exceeds len_reg-1. part_len=1023 is the maximum; no wrap.
- Simultaneous start and sample_valid in IDLE: start accepted, sample ignored and not flagged, because busy=0.

Test Plan:
1. Profile 100,200,300,400 with part_len=4 and samples 100,205,292,400 -> done once; pass=1, mismatch_count=0, mem_addr sequence 0,1,2,3.
2. Same profile with samples 100,209,300,400 -> pass=0, mismatch_count=1, first_fail_idx=1. Boundary check: diff 8 passes, diff 9 fails.
3. Profile of 3 words with samples 0,50,0,60,70 matching the profile -> zeros skipped, pass=1, exactly 3 compares.
4. part_len=5, END_MARK after 2 good samples -> fail_short=1, pass=0, done pulse. part_len=0 -> done 2 cycles after start, fail_short=1.
5. sample_valid asserted in the cycle after an accepted sample, during FETCH -> fail_overrun=1, pass=0. Sample profile 4095 against 0 -> no wrap, counted as mismatch.
6. rst asserted while in WAIT_SAMPLE at idx=2 -> all outputs 0 immediately, no done pulse. New start after rst release completes normally. Start pulsed while busy -> no restart.
